// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer for an external PRBS generator: seeds it, clocks it one bit per RUN cycle,
// and packs the serial bits MSB-first into words on a valid/ready stream.
module prbs_burst_ctrl #(
  parameter int unsigned SEED_W = 7,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SEED_W-1:0] seed,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              prbs_load,
  output logic [SEED_W-1:0] prbs_seed,
  output logic              prbs_en,
  input  logic              prbs_bit,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready
);

  localparam int unsigned BitCntW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] shifted;

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    // The bit captured this cycle lands in the LSB; the first bit ends up in the MSB.
    shifted      = {sr_q, prbs_bit};

    if (abort && (state_q != StIdle)) begin
      state_d      = StIdle;
      word_cnt_d   = '0;
      bit_cnt_d    = '0;
      sr_d         = '0;
      word_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            // An all-zero seed would lock the LFSR, so substitute 1.
            seed_d     = (seed == '0) ? SEED_W'(1) : seed;
            len_d      = burst_len;
            word_cnt_d = '0;
            state_d    = (burst_len == '0) ? StDone : StLoad;
          end
        end
        StLoad: begin
          bit_cnt_d = '0;
          state_d   = StRun;
        end
        StRun: begin
          sr_d = shifted[WORD_W-2:0];
          if (bit_cnt_q == BitCntW'(WORD_W - 1)) begin
            word_data_d  = shifted;
            word_valid_d = 1'b1;
            bit_cnt_d    = '0;
            state_d      = StHold;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
        StHold: begin
          if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
            if (word_cnt_q == len_q - LEN_W'(1)) begin
              word_cnt_d = '0;
              state_d    = StDone;
            end else begin
              word_cnt_d = word_cnt_q + LEN_W'(1);
              state_d    = StRun;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      seed_q       <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign prbs_load  = (state_q == StLoad);
  assign prbs_en    = (state_q == StRun);
  assign prbs_seed  = seed_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl: PRBS7 generator stand-in, per-cycle burst model, directed
// scenarios followed by randomized bursts with random backpressure, aborts and stray starts.
module tb_prbs_burst_ctrl;
  localparam int SW = 7;
  localparam int WW = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, abort, word_ready;
  logic [SW-1:0] seed;
  logic [LW-1:0] burst_len;
  logic          busy, done, prbs_load, prbs_en, prbs_bit, word_valid;
  logic [SW-1:0] prbs_seed;
  logic [WW-1:0] word_data;

  prbs_burst_ctrl #(.SEED_W(SW), .WORD_W(WW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
    .burst_len(burst_len), .busy(busy), .done(done), .prbs_load(prbs_load),
    .prbs_seed(prbs_seed), .prbs_en(prbs_en), .prbs_bit(prbs_bit),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready)
  );

  // PRBS7 generator, x^7 + x^6 + 1, output is the state MSB.
  logic [6:0] gen_s = 7'h00;
  always @(posedge clk) begin
    if (prbs_load) gen_s <= prbs_seed;
    else if (prbs_en) gen_s <= {gen_s[5:0], gen_s[6] ^ gen_s[5]};
  end
  assign prbs_bit = gen_s[6];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word k of a burst from seed sd: stream bits 8k..8k+7, first bit in the MSB.
  function automatic logic [7:0] ref_word(input logic [6:0] sd, input int k);
    logic [6:0] s;
    logic [7:0] w;
    s = (sd == 7'h00) ? 7'h01 : sd;
    w = 8'h00;
    for (int i = 0; i < 8 * k + 8; i++) begin
      if (i >= 8 * k) w = {w[6:0], s[6]};
      s = {s[5:0], s[6] ^ s[5]};
    end
    return w;
  endfunction

  // Monitor / model state
  bit         mon_on = 0;
  bit         m_busy = 0, m_done = 0, m_load = 0, m_rst = 1, m_abort = 0;
  logic [6:0] m_seed = 7'h00;
  int         m_len = 0, m_idx = 0;
  bit         p_hold = 0, prev_valid = 0, hs;
  logic [7:0] p_data = 8'h00;
  int         en_run = 0, done_cnt = 0, load_cnt = 0, en_cnt = 0;
  logic [7:0] hs_log[$];

  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("prbs_load", prbs_load, m_load);
      if (m_load) chk("prbs_seed", prbs_seed, m_seed);
      chk("load_en_exclusive", prbs_load & prbs_en, 0);
      if (m_rst)
        chk("post_reset_zero",
            {busy, done, prbs_load, prbs_en, word_valid, prbs_seed, word_data}, 0);
      if (m_abort) chk("valid_after_abort", word_valid, 0);
      if (word_valid) chk("en_in_hold", prbs_en, 0);
      if (p_hold) begin
        chk("hold_valid", word_valid, 1);
        chk("hold_data", word_data, p_data);
      end
      if (word_valid && !prev_valid) chk("bits_per_word", en_run, 8);

      if (done) done_cnt++;
      if (prbs_load) begin load_cnt++; en_run = 0; end
      if (prbs_en) begin en_cnt++; en_run++; end

      hs         = word_valid && word_ready && !abort && reset;
      p_hold     = word_valid && !hs && !abort && reset;
      p_data     = word_data;
      prev_valid = word_valid;
      if (hs) begin hs_log.push_back(word_data); en_run = 0; end

      m_rst   = !reset;
      m_abort = reset && abort && m_busy;
      m_load  = 0;
      if (!reset) begin
        m_busy = 0; m_done = 0;
      end else if (m_busy && abort) begin
        m_busy = 0; m_done = 0;
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_seed = (seed == 7'h00) ? 7'h01 : seed;
          m_len  = int'(burst_len);
          m_idx  = 0;
          m_done = (burst_len == 0);
          m_load = (burst_len != 0);
        end
      end else if (hs) begin
        chk("word_vs_model", word_data, ref_word(m_seed, m_idx));
        m_idx++;
        if (m_idx == m_len) m_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [6:0] s, input logic [15:0] l);
    seed = s; burst_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk({name, "_idle_timeout"}, busy, 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!word_valid && n < 100) begin tick(); n++; end
    chk({name, "_valid_timeout"}, word_valid, 1);
  endtask

  task automatic clear_log();
    hs_log.delete(); done_cnt = 0; load_cnt = 0; en_cnt = 0;
  endtask

  task automatic check_log(input string name, input int n, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c);
    logic [7:0] e[3];
    e = '{a, b, c};
    chk({name, "_count"}, hs_log.size(), n);
    for (int i = 0; i < n && i < hs_log.size(); i++) chk({name, "_word"}, hs_log[i], e[i]);
  endtask

  logic [6:0] rs;

  initial begin
    reset = 0; start = 0; abort = 0; seed = '0; burst_len = '0; word_ready = 0;

    chk("pin_ref_w0", ref_word(7'h01, 0), 8'h02);
    chk("pin_ref_w1", ref_word(7'h01, 1), 8'h0C);
    chk("pin_ref_w2", ref_word(7'h01, 2), 8'h28);
    chk("pin_ref_zero_seed", ref_word(7'h00, 1), 8'h0C);

    // 1: reset then a normal 3-word burst
    tick();
    mon_on = 1;
    tick();
    chk("reset_outputs",
        {busy, done, prbs_load, prbs_en, word_valid, prbs_seed, word_data}, 0);
    reset = 1; word_ready = 1;
    clear_log();
    go(7'h01, 16'd3);
    wait_idle("t1");
    check_log("t1", 3, 8'h02, 8'h0C, 8'h28);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_load_cnt", load_cnt, 1);
    chk("t1_en_cnt", en_cnt, 24);

    // 2: backpressure on the first word
    word_ready = 0;
    clear_log();
    go(7'h01, 16'd2);
    wait_valid("t2");
    repeat (5) tick();
    word_ready = 1;
    wait_idle("t2");
    check_log("t2", 2, 8'h02, 8'h0C, 8'h00);
    chk("t2_en_cnt", en_cnt, 16);

    // 3: zero seed, then zero length
    clear_log();
    go(7'h00, 16'd1);
    wait_idle("t3a");
    check_log("t3a", 1, 8'h02, 8'h00, 8'h00);
    clear_log();
    go(7'h33, 16'd0);
    chk("t3b_done", done, 1);
    chk("t3b_busy", busy, 1);
    tick();
    chk("t3b_done_after", done, 0);
    chk("t3b_idle", busy, 0);
    chk("t3b_no_load", load_cnt, 0);
    chk("t3b_no_word", hs_log.size(), 0);

    // 4: abort in HOLD of word 2 together with ready
    word_ready = 0;
    clear_log();
    go(7'h01, 16'd4);
    wait_valid("t4a");
    word_ready = 1;
    tick();
    word_ready = 0;
    wait_valid("t4b");
    abort = 1; word_ready = 1;
    tick();
    abort = 0; word_ready = 0;
    chk("t4_busy", busy, 0);
    chk("t4_valid", word_valid, 0);
    repeat (3) tick();
    chk("t4_no_done", done_cnt, 0);
    check_log("t4", 1, 8'h02, 8'h00, 8'h00);
    word_ready = 1;
    clear_log();
    go(7'h01, 16'd1);
    wait_idle("t4c");
    check_log("t4c", 1, 8'h02, 8'h00, 8'h00);

    // 5: start while busy is ignored
    clear_log();
    go(7'h01, 16'd2);
    repeat (3) tick();
    seed = 7'h55; burst_len = 16'd5; start = 1;
    tick();
    start = 0;
    wait_idle("t5");
    check_log("t5", 2, 8'h02, 8'h0C, 8'h00);
    chk("t5_load_cnt", load_cnt, 1);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: reset mid-burst
    go(7'h01, 16'd3);
    repeat (3) tick();
    reset = 0;
    tick();
    reset = 1;
    chk("t6_reset_outputs",
        {busy, done, prbs_load, prbs_en, word_valid, prbs_seed, word_data}, 0);
    clear_log();
    go(7'h01, 16'd1);
    wait_idle("t6");
    check_log("t6", 1, 8'h02, 8'h00, 8'h00);
    chk("t6_load_cnt", load_cnt, 1);

    // Random bursts: the monitor model checks every cycle
    for (int it = 0; it < 40; it++) begin
      int n;
      rs = 7'($urandom);
      word_ready = 1'($urandom_range(0, 1));
      go(rs, 16'($urandom_range(0, 4)));
      n = 0;
      while (busy && n < 600) begin
        word_ready = 1'($urandom_range(0, 1));
        abort      = ($urandom_range(0, 59) == 0);
        start      = ($urandom_range(0, 9) == 0);
        seed       = 7'($urandom);
        burst_len  = 16'($urandom_range(0, 4));
        tick();
        n++;
      end
      abort = 0; start = 0;
      chk("rand_idle_timeout", busy, 0);
      abort = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) tick();
      abort = 0;
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
